// File: rtl/wc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wc_pkg
// Description : Shared constants and types for the WC_2_3 sequencer: pad word
//               width, command codes carried in the top two bits of a command
//               word, and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wc_pkg;

  localparam int DW = 10;

  localparam logic [1:0] CMD_NOP        = 2'b00;
  localparam logic [1:0] CMD_LOAD_G     = 2'b01;
  localparam logic [1:0] CMD_TILE_FIRST = 2'b10;
  localparam logic [1:0] CMD_TILE_NEXT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_G = 3'd1,
    LD_D = 3'd2,
    RUN  = 3'd3,
    WAIT = 3'd4,
    OUT  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wc_tile_win.sv
`default_nettype none
// ============================================================================
// Module      : wc_tile_win
// Description : Four-entry input tile register for the F(2,3) core. Supports
//               indexed writes (full tile load, or the last word of a sliding
//               tile) and a shift-by-2 write that keeps d2/d3 as the overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module wc_tile_win #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [1:0]    ld_idx,
  input  logic          shift_en,
  input  logic [DW-1:0] word,
  output logic [4*DW-1:0] tile
);

  logic [DW-1:0] r_d [4];

  // Tile storage: shift-by-2 takes priority over an indexed write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_d[i] <= '0;
    end else if (shift_en) begin
      r_d[0] <= r_d[2];
      r_d[1] <= r_d[3];
      r_d[2] <= word;
    end else if (ld_en) begin
      r_d[ld_idx] <= word;
    end
  end

  assign tile = {r_d[3], r_d[2], r_d[1], r_d[0]};

endmodule
`default_nettype wire

// File: rtl/wc_2_3_seq.sv
`default_nettype none
// ============================================================================
// Module      : wc_2_3_seq
// Description : Pad-bus sequencer for the Winograd F(2,3) core. Decodes
//               command words, loads filter taps and the input tile (full or
//               stride-2 sliding), pulses core_start, captures the two results
//               and streams them out over a valid/ready handshake.
//               Optional macro WC_SEQ_TIMEOUT_EN adds a core_done watchdog of
//               TO_CYC cycles in WAIT.
//               Note: rst is asynchronous and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module wc_2_3_seq #(
  parameter int DW     = wc_pkg::DW,
  parameter int TO_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            in_ready,
  output logic [3*DW-1:0] core_g,
  output logic [4*DW-1:0] core_d,
  output logic            core_start,
  input  logic            core_done,
  input  logic [DW-1:0]   core_y0,
  input  logic [DW-1:0]   core_y1,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  output logic            err
);

  import wc_pkg::*;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_g0, r_g1, r_g2;
  logic [DW-1:0] r_y0, r_y1;
  logic [1:0]    r_idx;
  logic          r_next, r_tile_ok, r_err, r_out_sel, r_live;
  logic          w_in_acc, w_idx_last, w_err_set, w_timeout;
  logic          w_td_ld, w_td_shift;
  logic [1:0]    w_td_idx;
  logic [1:0]    w_cmd;

  assign w_cmd      = in_data[DW-1:DW-2];
  assign w_in_acc   = in_valid && in_ready;
  assign w_idx_last = r_next ? (r_idx == 2'd1) : (r_idx == 2'd3);

  // Next state, handshake and tile-write controls
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    core_start  = 1'b0;
    w_td_ld     = 1'b0;
    w_td_shift  = 1'b0;
    w_td_idx    = r_idx;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = r_live;
        if (w_in_acc) begin
          case (w_cmd)
            CMD_LOAD_G:     w_state_nxt = LD_G;
            CMD_TILE_FIRST: w_state_nxt = LD_D;
            CMD_TILE_NEXT: begin
              if (r_tile_ok) w_state_nxt = LD_D;
              else           w_err_set   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      LD_G: begin
        in_ready = r_live;
        if (w_in_acc && r_idx == 2'd2) w_state_nxt = IDLE;
      end
      LD_D: begin
        in_ready = r_live;
        if (w_in_acc) begin
          if (r_next) begin
            // Sliding tile: first word shifts the window, second fills d3
            if (r_idx == 2'd0) begin
              w_td_shift = 1'b1;
            end else begin
              w_td_ld  = 1'b1;
              w_td_idx = 2'd3;
            end
          end else begin
            w_td_ld = 1'b1;
          end
          if (w_idx_last) w_state_nxt = RUN;
        end
      end
      RUN: begin
        core_start  = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          w_state_nxt = OUT;
        end else if (w_timeout) begin
          w_err_set   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      OUT: begin
        if (out_ready && r_out_sel) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // A result pulse the sequencer is not waiting for is a protocol error
    if (core_done && r_state != WAIT) w_err_set = 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // in_ready is held low while reset is active and until the first clock after
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

  // Operand position counter and tile-mode flag latched at command time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= 2'd0;
      r_next <= 1'b0;
    end else if (r_state == IDLE) begin
      r_idx <= 2'd0;
      if (w_in_acc) r_next <= (w_cmd == CMD_TILE_NEXT);
    end else if (w_in_acc) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Filter tap registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g0 <= '0;
      r_g1 <= '0;
      r_g2 <= '0;
    end else if (r_state == LD_G && w_in_acc) begin
      case (r_idx)
        2'd0:    r_g0 <= in_data;
        2'd1:    r_g1 <= in_data;
        default: r_g2 <= in_data;
      endcase
    end
  end

  // tile_ok: a complete tile exists that a sliding load can build on
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         r_tile_ok <= 1'b0;
    else if (r_state == WAIT && !core_done && w_timeout) r_tile_ok <= 1'b0;
    else if (r_state == LD_D && w_in_acc && w_idx_last)  r_tile_ok <= 1'b1;
  end

  // Sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  // Result capture on the awaited core_done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y0 <= '0;
      r_y1 <= '0;
    end else if (r_state == WAIT && core_done) begin
      r_y0 <= core_y0;
      r_y1 <= core_y1;
    end
  end

  // Output word select: toggles on each handshake, back to y0 after y1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            r_out_sel <= 1'b0;
    else if (r_state == OUT && out_ready) r_out_sel <= ~r_out_sel;
  end

`ifdef WC_SEQ_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TO_CYC + 1);
  logic [c_TO_W-1:0] r_to_cnt;

  // Watchdog counts cycles spent in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_to_cnt <= '0;
    else if (r_state == WAIT) r_to_cnt <= r_to_cnt + 1'b1;
    else                     r_to_cnt <= '0;
  end

  assign w_timeout = (r_state == WAIT) && (r_to_cnt == c_TO_W'(TO_CYC - 1));
`else
  // Watchdog absent: WAIT is held until core_done
  logic w_unused_to;
  assign w_unused_to = ^TO_CYC;
  assign w_timeout   = 1'b0;
`endif

  wc_tile_win #(.DW(DW)) u_tile (
    .clk      (clk),
    .rst      (rst),
    .ld_en    (w_td_ld),
    .ld_idx   (w_td_idx),
    .shift_en (w_td_shift),
    .word     (in_data),
    .tile     (core_d)
  );

  assign core_g    = {r_g2, r_g1, r_g0};
  assign out_valid = (r_state == OUT);
  assign out_data  = out_valid ? (r_out_sel ? r_y1 : r_y0) : '0;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/wc_2_3_seq.md
Name: wc_2_3_seq

Overview:
- Sequencer for the Winograd F(2,3) convolution core (WC_2_3) behind the 10-bit chip pad bus.
- Accepts command and operand words from the input pads and holds the 3 filter taps and the 4-sample input tile.
- Maintains the sliding tile window at stride 2, starts the core, and streams the 2 results back to the output pads with a valid/ready handshake.
- Sits between the pad ring and WC_2_3 inside CHIP.

Parameters:
DW, 10, width of pad words, operands and results
TO_CYC, 64, core_done watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  in_data holds a word
in_data  in  DW  command or operand word
in_ready  out  1  word accepted when in_valid && in_ready
core_g  out  3*DW  filter taps g0..g2, g0 in LSBs
core_d  out  4*DW  tile d0..d3, d0 in LSBs
core_start  out  1  one-cycle start pulse to core
core_done  in  1  one-cycle pulse; core_y0/core_y1 valid that cycle
core_y0  in  DW  result y0
core_y1  in  DW  result y1
out_valid  out  1  out_data holds a result
out_data  out  DW  result word
out_ready  in  1  sink accepts when out_valid && out_ready
err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - All g, d, y registers clear to 0.
  - in_ready, core_start, out_valid, out_data, err all 0.
  - tile_ok cleared.
- Command word (accepted in IDLE), cmd = in_data[DW-1:DW-2]:
  - 00 NOP: no effect.
  - 01 LOAD_G: go to LD_G.
  - 10 TILE_FIRST: go to LD_D with cnt = 4.
  - 11 TILE_NEXT: if tile_ok, go to LD_D with cnt = 2. If tile_ok is 0, set err, stay in IDLE, word is consumed.
- in_ready:
  - 1 in IDLE, LD_G and LD_D.
  - 0 in RUN, WAIT and OUT.
- LD_G:
  - The 3 accepted words go to g0, g1, g2 in order.
  - Go to IDLE after the third word.
  - Loading taps does not change tile_ok.
- LD_D, first tile: the 4 words go to d0..d3 in order.
- LD_D, next tile:
  - On the first accepted word: d0 <= d2, d1 <= d3, d2 <= word.
  - On the second accepted word: d3 <= word.
  - The previous d2/d3 are retained as the overlap.
- After the last LD_D word: go to RUN and set tile_ok.
- RUN: core_start = 1 for exactly one cycle, then go to WAIT.
- WAIT: on core_done, capture y0 and y1, then go to OUT.
- OUT:
  - out_data = y0 with out_valid = 1.
  - On handshake, out_data = y1 the next cycle.
  - On the second handshake, out_valid drops and the FSM goes to IDLE.
  - out_data and out_valid hold while out_ready is low.
- Latency:
  - core_start is asserted the cycle after the last operand word is accepted.
  - out_valid is asserted the cycle after core_done.
- core_done outside WAIT is ignored and sets err.
- Arithmetic: none. All data is passed through at DW width with no sign handling; the core owns the arithmetic.
- err is sticky until reset.
- Reset mid-frame aborts immediately. Partially loaded words are discarded (registers cleared).

Optional Feature:
- Macro: WC_SEQ_TIMEOUT_EN.
- With the macro:
  - A counter runs in WAIT.
  - If TO_CYC cycles elapse without core_done: set err, clear tile_ok, go to IDLE, out_valid stays 0.
  - A core_done arriving after the timeout is ignored and sets err.
- Without the macro: no counter; WAIT is held indefinitely.

Decomposition:
- Package wc_pkg holds:
  - DW default.
  - Command code constants CMD_NOP, CMD_LOAD_G, CMD_TILE_FIRST, CMD_TILE_NEXT.
  - State enum IDLE, LD_G, LD_D, RUN, WAIT, OUT.
- One sub-module, wc_tile_win: the 4-entry tile register with load-full and shift-by-2 modes. It drives core_d.

Test Plan:
- Load taps then first tile: LOAD_G, 3, 5, 7; TILE_FIRST, 1, 2, 3, 4 -> core_g = {7,5,3}, core_d = {4,3,2,1}, one core_start pulse one cycle after word 4. Model core_done with y0 = 34, y1 = 49 -> out_data 34 then 49.
- Sliding tile: after the above, TILE_NEXT, 5, 6 -> core_d = {6,5,4,3} at core_start, taps unchanged.
- TILE_NEXT right after reset -> err = 1, no core_start, FSM in IDLE, in_ready = 1.
- Output backpressure: out_ready low 5 cycles in OUT -> out_valid = 1 and out_data = y0 held stable; in_ready = 0 throughout.
- Async reset asserted during LD_D after 2 words -> all outputs 0 immediately. Subsequent TILE_NEXT flags err.
- With WC_SEQ_TIMEOUT_EN, TO_CYC = 8: no core_done -> err = 1 and FSM back in IDLE after 8 WAIT cycles. Without the macro, the FSM stays in WAIT.
